// File: rtl/load_pkg.sv
// Shared definitions for the load unit: op encodings, FSM states, address check.
// Build option: LOAD_LWLR_EN enables the unaligned LWL/LWR merge loads.
package load_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LWL = 3'b010;
    localparam logic [2:0] OP_LW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_LWR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // High when the access must raise AdEL: misaligned or an op that is not decoded.
    function automatic logic load_addr_err(input logic [2:0] op, input logic [1:0] k);
        logic err;
        err = 1'b0;
        case (op)
            OP_LB, OP_LBU: err = 1'b0;
            OP_LH, OP_LHU: err = k[0];
            OP_LW:         err = (k != 2'b00);
`ifdef LOAD_LWLR_EN
            OP_LWL, OP_LWR: err = 1'b0;
`endif
            default:       err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/byte_extract.sv
// Combinational lane select and extension for loads (big-endian lanes).
// Build option: LOAD_LWLR_EN adds the LWL/LWR merge with rt.
module byte_extract
    import load_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  k_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rt_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

`ifndef LOAD_LWLR_EN
    // rt only feeds the merge loads, which are absent in this build.
    logic unused_rt;
    assign unused_rt = ^rt_i;
`endif

    // Pick the addressed byte lane; k=0 is the most significant lane.
    always_comb begin
        byte_sel = word_i[31:24];
        case (k_i)
            2'd0: byte_sel = word_i[31:24];
            2'd1: byte_sel = word_i[23:16];
            2'd2: byte_sel = word_i[15:8];
            2'd3: byte_sel = word_i[7:0];
            default: byte_sel = word_i[31:24];
        endcase
    end

    assign half_sel = k_i[1] ? word_i[15:0] : word_i[31:16];

    // Extend or merge according to the op; undecoded ops produce 0.
    always_comb begin
        data_o = 32'h0;
        case (op_i)
            OP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: data_o = {24'h0, byte_sel};
            OP_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU: data_o = {16'h0, half_sel};
            OP_LW:  data_o = word_i;
`ifdef LOAD_LWLR_EN
            OP_LWL: begin
                case (k_i)
                    2'd0: data_o = word_i;
                    2'd1: data_o = {word_i[23:0], rt_i[7:0]};
                    2'd2: data_o = {word_i[15:0], rt_i[15:0]};
                    2'd3: data_o = {word_i[7:0], rt_i[23:0]};
                    default: data_o = word_i;
                endcase
            end
            OP_LWR: begin
                case (k_i)
                    2'd0: data_o = {rt_i[31:8], word_i[31:24]};
                    2'd1: data_o = {rt_i[31:16], word_i[31:16]};
                    2'd2: data_o = {rt_i[31:24], word_i[31:8]};
                    2'd3: data_o = word_i;
                    default: data_o = word_i;
                endcase
            end
`endif
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_align.sv
// MEM-stage load unit: word-aligned read, wait for ack, extract/extend, hold result.
// Build option: LOAD_LWLR_EN enables LWL/LWR (otherwise ops 010/110 raise AdEL).
module load_align
    import load_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_rt_i,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o
);

    state_e      state_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] rt_q;
    logic        req_ready_q;
    logic        mem_rd_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic [31:0] ext_data;

    byte_extract u_extract (
        .word_i (mem_rdata_i),
        .k_i    (addr_q[1:0]),
        .op_i   (op_q),
        .rt_i   (rt_q),
        .data_o (ext_data)
    );

    // Request/response FSM; every output comes straight from a register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'b000;
            addr_q      <= 32'h0;
            rt_q        <= 32'h0;
            req_ready_q <= 1'b1;
            mem_rd_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_q        <= req_op_i;
                        addr_q      <= req_addr_i;
                        rt_q        <= req_rt_i;
                        req_ready_q <= 1'b0;
                        if (load_addr_err(req_op_i, req_addr_i[1:0])) begin
                            // Address error: answer without touching memory.
                            state_q     <= ST_DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= 32'h0;
                        end else begin
                            state_q  <= ST_WAIT;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i) begin
                        state_q     <= ST_DONE;
                        mem_rd_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= ext_data;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    mem_rd_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_load_align.sv
// Self-checking bench for load_align: directed cases plus random loads against
// an arithmetic reference model.
module tb_load_align;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_rt;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_data;
    logic        last_err;

    load_align dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_addr_i  (req_addr),
        .req_rt_i    (req_rt),
        .mem_rd_o    (mem_rd),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: {err, data} computed with shifts and masks on wide integers.
    function automatic logic [32:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                              input logic [31:0] word, input logic [31:0] rt);
        longint unsigned w;
        longint unsigned r;
        longint unsigned mask;
        longint v;
        int k;
        bit lwlr;
        w = 64'(word);
        r = 64'(rt);
        k = int'(addr[1:0]);
`ifdef LOAD_LWLR_EN
        lwlr = 1'b1;
`else
        lwlr = 1'b0;
`endif
        case (op)
            3'b000, 3'b100: begin
                v = longint'((w >> (24 - 8 * k)) & 64'hFF);
                if (op == 3'b000 && v > 127) v = v - 256;
                return {1'b0, v[31:0]};
            end
            3'b001, 3'b101: begin
                if (k % 2 != 0) return {1'b1, 32'h0};
                v = longint'((w >> (16 - 8 * k)) & 64'hFFFF);
                if (op == 3'b001 && v > 32767) v = v - 65536;
                return {1'b0, v[31:0]};
            end
            3'b011: begin
                if (k != 0) return {1'b1, 32'h0};
                return {1'b0, word};
            end
            3'b010: begin
                if (!lwlr) return {1'b1, 32'h0};
                mask = (64'd1 << (8 * k)) - 1;
                w = ((w << (8 * k)) | (r & mask)) & 64'hFFFF_FFFF;
                return {1'b0, w[31:0]};
            end
            3'b110: begin
                if (!lwlr) return {1'b1, 32'h0};
                mask = (64'd1 << (8 * (k + 1))) - 1;
                w = ((w >> (24 - 8 * k)) | (r & ~mask)) & 64'hFFFF_FFFF;
                return {1'b0, w[31:0]};
            end
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // One full transaction: accept, optional wait/ack, hold, handshake out.
    task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] word,
                           input logic [31:0] rt, input int dly, input int hold);
        logic [32:0] r;
        int guard;
        r = ref_load(op, addr, word, rt);
        guard = 0;
        while (!req_ready && guard < 20) begin
            step();
            guard++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_rt    = rt;
        step();
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_rt    = $urandom;
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (!r[32]) begin
            for (int i = 0; i < dly; i++) begin
                chk("wait_mem_rd", 32'(mem_rd), 32'd1);
                chk("wait_mem_addr", mem_addr, {addr[31:2], 2'b00});
                chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                mem_rdata = $urandom;
                step();
            end
            chk("ack_mem_rd", 32'(mem_rd), 32'd1);
            mem_ack   = 1'b1;
            mem_rdata = word;
            step();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mem_rd_done", 32'(mem_rd), 32'd0);
        chk("rsp_err", 32'(rsp_err), 32'(r[32]));
        chk("rsp_data", rsp_data, r[31:0]);
        last_data = rsp_data;
        last_err  = rsp_err;
        for (int h = 0; h < hold; h++) begin
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
            chk("hold_data", rsp_data, r[31:0]);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_mem_rd", 32'(mem_rd), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_addr  = 32'h0;
        req_rt    = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        step();

        // Ack while idle must be ignored.
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_valid", 32'(rsp_valid), 32'd0);
        chk("idle_ack_mem_rd", 32'(mem_rd), 32'd0);

        do_load(3'b000, 32'h101, 32'h1280_3456, 32'h0, 3, 0);
        chk("lb_const", last_data, 32'hFFFF_FF80);
        do_load(3'b100, 32'h101, 32'h1280_3456, 32'h0, 3, 0);
        chk("lbu_const", last_data, 32'h0000_0080);
        do_load(3'b001, 32'h202, 32'hAAAA_8001, 32'h0, 1, 0);
        chk("lh_const", last_data, 32'hFFFF_8001);
        do_load(3'b001, 32'h201, 32'hAAAA_8001, 32'h0, 0, 1);
        chk("lh_mis_err", 32'(last_err), 32'd1);
        do_load(3'b011, 32'h300, 32'hDEAD_BEEF, 32'h0, 0, 4);
        chk("lw_const", last_data, 32'hDEAD_BEEF);
        do_load(3'b010, 32'h401, 32'h1122_3344, 32'hAABB_CCDD, 2, 0);
`ifdef LOAD_LWLR_EN
        chk("lwl_const", last_data, 32'h2233_44DD);
`else
        chk("lwl_err", 32'(last_err), 32'd1);
`endif
        do_load(3'b110, 32'h401, 32'h1122_3344, 32'hAABB_CCDD, 2, 0);
`ifdef LOAD_LWLR_EN
        chk("lwr_const", last_data, 32'hAABB_1122);
`else
        chk("lwr_err", 32'(last_err), 32'd1);
`endif
        do_load(3'b111, 32'h500, 32'h1234_5678, 32'h0, 0, 1);
        chk("ill_err", 32'(last_err), 32'd1);

        // Reset while waiting for memory; the late ack must be dropped.
        req_valid = 1'b1;
        req_op    = 3'b011;
        req_addr  = 32'h600;
        step();
        req_valid = 1'b0;
        chk("rstw_mem_rd_before", 32'(mem_rd), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_mem_rd", 32'(mem_rd), 32'd0);
        chk("rstw_req_ready", 32'(req_ready), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 1'b0;
        chk("rstw_late_valid", 32'(rsp_valid), 32'd0);
        chk("rstw_late_mem_rd", 32'(mem_rd), 32'd0);
        chk("rstw_late_ready", 32'(req_ready), 32'd1);

        // Reset while holding an error response.
        req_valid = 1'b1;
        req_op    = 3'b111;
        step();
        req_valid = 1'b0;
        chk("rstd_valid_before", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstd_valid", 32'(rsp_valid), 32'd0);
        chk("rstd_ready", 32'(req_ready), 32'd1);

        for (int n = 0; n < 60; n++) begin
            op   = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            do_load(op, addr, $urandom, $urandom, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_align.md
# load_align

Memory-stage load unit for the 5-cycle MIPS core: the read-side counterpart of the store-side byte insert. It accepts a load request from the MEM stage, issues a word-aligned read to data memory, waits a variable number of cycles for acknowledge, then extracts and sign- or zero-extends the addressed byte, halfword or word. Lane numbering is big-endian. It also flags misaligned accesses (AdEL) without touching memory and holds its result until the pipeline takes it.

## Interface
Parameters: none (fixed 32-bit datapath).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_op  in  3  opcode[2:0]: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU, 010 LWL, 110 LWR; 111 illegal
- req_addr  in  32  effective byte address
- req_rt  in  32  current rt value, merge source for LWL/LWR
- mem_rd  out  1  read strobe, held until mem_ack
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_rdata  in  32  read word, valid when mem_ack=1
- mem_ack  in  1  read completes this cycle
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  32  extended or merged load value
- rsp_err  out  1  address error (misaligned or illegal op); rsp_data=0 when set

## Operation
- States: IDLE, WAIT, DONE. Reset → IDLE, with all outputs 0 except req_ready=1.
- IDLE: on req_valid, latch op, addr and rt.
  - Misaligned (LH/LHU with addr[0]=1, LW with addr[1:0]≠0) or op=111 → DONE with rsp_err=1. No mem_rd is issued.
  - Otherwise → WAIT.
- WAIT: mem_rd=1 and mem_addr stable. On mem_ack, capture the extracted result → DONE.
- DONE: rsp_valid=1; rsp_data and rsp_err are held stable. On rsp_ready → IDLE.
- Extraction, with k = addr[1:0]:
  - Byte: bits [31-8k -: 8]; k=0 selects the MSB lane.
  - Half: k=0 → [31:16]; k=2 → [15:0].
  - Sign extension for LB/LH; zero extension for LBU/LHU.
- LWL: {word[31-8k:0], rt[8k-1:0]}; k=0 gives the whole word.
- LWR: {rt[31:8(k+1)], word[31:24-8k]}; k=3 gives the whole word.
- mem_ack outside WAIT is ignored.
- req_valid outside IDLE is ignored, because req_ready=0.

## Timing
- Request accepted at edge 0. mem_rd rises in cycle 1. Minimum latency: mem_ack in cycle 1 gives rsp_valid in cycle 2.
- Error path: rsp_valid in cycle 1, and mem_rd never rises.
- rsp_valid∧rsp_ready in cycle n gives req_ready=1 in cycle n+1. There is no back-to-back accept in the same cycle as the response.
- mem_rd stays high for an arbitrary number of cycles until mem_ack. It deasserts on the edge after ack.
- rsp_data is registered, so there is no combinational path from mem_rdata to rsp_data.
- rst mid-operation (WAIT or DONE): at the next edge go to IDLE, drop mem_rd and rsp_valid, and discard the pending result. A late mem_ack is ignored.

## Configuration
- LOAD_LWLR_EN defined: LWL/LWR are decoded as described above, and req_rt is used.
- LOAD_LWLR_EN undefined: ops 010 and 110 are treated as illegal (rsp_err=1, no memory access), and req_rt is unused.

## Structure
- Shared package load_pkg holds:
  - op encodings (OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR);
  - the state enum (ST_IDLE, ST_WAIT, ST_DONE);
  - a misalignment-check function.
- Sub-module byte_extract: purely combinational. Takes (word, k, op, rt) and produces the extended or merged value. The top level contains only the FSM and registers.

## Test plan
- LB at addr 0x101, mem_rdata=0x1280_3456, ack after 3 cycles → rsp_data=0xFFFF_FF80, err=0. LBU at the same address → 0x0000_0080.
- LH at 0x202 with mem_rdata=0xAAAA_8001 → 0xFFFF_8001. LH at 0x201 → err=1, rsp_data=0, mem_rd never asserted.
- LW at 0x300, mem_ack in the first WAIT cycle → rsp_valid exactly 2 cycles after accept. Hold rsp_ready=0 for 4 cycles → rsp_data stays stable and req_ready stays 0.
- LWL at 0x401 (k=1), word=0x1122_3344, rt=0xAABB_CCDD → 0x2233_44DD. LWR at 0x401 → 0xAABB_1122. Without LOAD_LWLR_EN, both give err=1.
- Assert rst in WAIT → mem_rd=0 next cycle. A subsequent mem_ack is ignored, rsp_valid stays 0, and req_ready=1.
- req_op=111 → err=1 with no memory access.
